// File: rtl/instruction_fetch_pkg.sv
// Shared types and defaults for the fetch stage.
package instruction_fetch_pkg;

   typedef enum logic {
      FETCH_IDLE = 1'b0,
      FETCH_WAIT = 1'b1
   } fetch_state_t;

   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0,x0,0

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory read port: req/ack handshake with word-aligned address.
interface instruction_fetch_if;

   logic [31:0] mem_addr;
   logic        mem_req;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_addr,
      output mem_req,
      input  mem_rdata,
      input  mem_ack
   );

   modport slave (
      input  mem_addr,
      input  mem_req,
      output mem_rdata,
      output mem_ack
   );

endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues word reads and latches the returned word into IR.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       fetch_en,
   input  logic                       pc_write,
   input  logic [31:0]                pc_next,
   instruction_fetch_if.master        mem,
   output logic [31:0]                instr,
   output logic [31:0]                pc,
   output logic [31:0]                pc_old,
   output logic                       instr_valid,
   output logic                       busy,
   output logic                       misalign_err
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  pc_old_q, pc_old_d;
   logic [31:0]  ir_q, ir_d;
   logic         valid_q, valid_d;
   logic         misalign_q, misalign_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FETCH_IDLE;
         pc_q       <= RESET_PC;
         pc_old_q   <= RESET_PC;
         ir_q       <= NOP_INSTR;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pc_old_q   <= pc_old_d;
         ir_q       <= ir_d;
         valid_q    <= valid_d;
         misalign_q <= misalign_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pc_old_d   = pc_old_q;
      ir_d       = ir_q;
      valid_d    = valid_q;
      misalign_d = misalign_q;

      unique case (state_q)
         FETCH_IDLE: begin
            // PC load takes effect together with a same-cycle fetch, so WAIT sees the new address.
            if (pc_write) begin
               pc_d = word_align(pc_next);
               if (pc_next[1:0] != 2'b00) misalign_d = 1'b1;
            end
            if (fetch_en) begin
               state_d = FETCH_WAIT;
               valid_d = 1'b0;
            end
         end
         FETCH_WAIT: begin
            if (mem.mem_ack) begin
               ir_d     = mem.mem_rdata;
               pc_old_d = pc_q;
               pc_d     = pc_q + 32'd4;
               valid_d  = 1'b1;
               state_d  = FETCH_IDLE;
            end
         end
         default: state_d = FETCH_IDLE;
      endcase
   end

   assign mem.mem_addr = pc_q;
   assign mem.mem_req  = (state_q == FETCH_WAIT);
   assign busy         = (state_q == FETCH_WAIT);
   assign instr        = ir_q;
   assign pc           = pc_q;
   assign pc_old       = pc_old_q;
   assign instr_valid  = valid_q;
   assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a scoreboard of expected completed fetches.
module tb_instruction_fetch;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc_old;
      logic [31:0] pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_en;
   logic        pc_write;
   logic [31:0] pc_next;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_old;
   logic        instr_valid;
   logic        busy;
   logic        misalign_err;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   instruction_fetch_if mem_if ();

   instruction_fetch dut (
      .clk          (clk),
      .reset        (reset),
      .fetch_en     (fetch_en),
      .pc_write     (pc_write),
      .pc_next      (pc_next),
      .mem          (mem_if),
      .instr        (instr),
      .pc           (pc),
      .pc_old       (pc_old),
      .instr_valid  (instr_valid),
      .busy         (busy),
      .misalign_err (misalign_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Pops the oldest expected fetch and compares it against the DUT outputs.
   task automatic check_done(input string tag);
      exp_t e;
      n_checks++;
      assert (sb.size() > 0) else begin
         n_fail++;
         $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_instr"},  instr,  e.instr);
         chk({tag, "_pcold"},  pc_old, e.pc_old);
         chk({tag, "_pc"},     pc,     e.pc);
         chk({tag, "_valid"},  {31'd0, instr_valid}, 32'd1);
         chk({tag, "_req_lo"}, {31'd0, mem_if.mem_req}, 32'd0);
      end
   endtask

   // One fetch: fetch_en (optionally with pc_write) for a cycle, then n WAIT cycles, ack in the last.
   task automatic do_fetch(input string tag, input int n_wait, input logic pw,
                           input logic [31:0] pn, input logic [31:0] exp_addr,
                           input logic [31:0] rdata, input logic disturb);
      exp_t e;
      fetch_en = 1'b1;
      pc_write = pw;
      pc_next  = pn;
      tick();
      fetch_en = 1'b0;
      pc_write = 1'b0;
      for (int i = 0; i < n_wait; i++) begin
         chk({tag, "_req"},   {31'd0, mem_if.mem_req}, 32'd1);
         chk({tag, "_busy"},  {31'd0, busy}, 32'd1);
         chk({tag, "_addr"},  mem_if.mem_addr, exp_addr);
         chk({tag, "_vlo"},   {31'd0, instr_valid}, 32'd0);
         if (disturb) begin
            fetch_en = 1'b1;
            pc_write = 1'b1;
            pc_next  = 32'h0000_0203;
         end
         if (i == n_wait - 1) begin
            mem_if.mem_ack   = 1'b1;
            mem_if.mem_rdata = rdata;
            e.instr  = rdata;
            e.pc_old = exp_addr;
            e.pc     = exp_addr + 32'd4;
            sb.push_back(e);
         end
         tick();
         mem_if.mem_ack   = 1'b0;
         mem_if.mem_rdata = 32'h0;
         fetch_en = 1'b0;
         pc_write = 1'b0;
      end
      check_done(tag);
   endtask

   initial begin
      reset            = 1'b1;
      fetch_en         = 1'b0;
      pc_write         = 1'b0;
      pc_next          = 32'h0;
      mem_if.mem_ack   = 1'b0;
      mem_if.mem_rdata = 32'h0;
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) tick();

      chk("rst_pc",       pc, 32'h0);
      chk("rst_pcold",    pc_old, 32'h0);
      chk("rst_instr",    instr, 32'h0000_0013);
      chk("rst_valid",    {31'd0, instr_valid}, 32'd0);
      chk("rst_req",      {31'd0, mem_if.mem_req}, 32'd0);
      chk("rst_busy",     {31'd0, busy}, 32'd0);
      chk("rst_misalign", {31'd0, misalign_err}, 32'd0);

      // Basic fetch, ack on the third WAIT cycle.
      do_fetch("f1", 3, 1'b0, 32'h0, 32'h0, 32'h0050_0093, 1'b0);

      // Back-to-back with a same-cycle PC load.
      do_fetch("f2", 2, 1'b1, 32'h0000_0100, 32'h0000_0100, 32'h1234_5678, 1'b0);

      // Misaligned PC load: rounded down, sticky error, valid untouched.
      pc_write = 1'b1;
      pc_next  = 32'h0000_0102;
      tick();
      pc_write = 1'b0;
      chk("mis_pc",    pc, 32'h0000_0100);
      chk("mis_err",   {31'd0, misalign_err}, 32'd1);
      chk("mis_valid", {31'd0, instr_valid}, 32'd1);
      chk("mis_instr", instr, 32'h1234_5678);

      // Control pulses during WAIT must not move the PC.
      do_fetch("f3", 3, 1'b0, 32'h0, 32'h0000_0100, 32'hCAFE_0013, 1'b1);
      chk("f3_err", {31'd0, misalign_err}, 32'd1);

      // PC wrap at the top of the address space, minimum latency.
      do_fetch("f4", 1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0073, 1'b0);

      // Reset in the middle of WAIT; the late ack is ignored.
      fetch_en = 1'b1;
      pc_write = 1'b1;
      pc_next  = 32'h0000_0040;
      tick();
      fetch_en = 1'b0;
      pc_write = 1'b0;
      chk("rw_req", {31'd0, mem_if.mem_req}, 32'd1);
      chk("rw_addr", mem_if.mem_addr, 32'h0000_0040);
      reset = 1'b1;
      tick();
      reset            = 1'b0;
      mem_if.mem_ack   = 1'b1;
      mem_if.mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_if.mem_ack   = 1'b0;
      mem_if.mem_rdata = 32'h0;
      chk("rw_busy",     {31'd0, busy}, 32'd0);
      chk("rw_instr",    instr, 32'h0000_0013);
      chk("rw_pc",       pc, 32'h0);
      chk("rw_pcold",    pc_old, 32'h0);
      chk("rw_valid",    {31'd0, instr_valid}, 32'd0);
      chk("rw_misalign", {31'd0, misalign_err}, 32'd0);

      // Spurious ack in IDLE after a normal fetch leaves IR alone.
      do_fetch("f5", 2, 1'b0, 32'h0, 32'h0, 32'h0010_0113, 1'b0);
      mem_if.mem_ack   = 1'b1;
      mem_if.mem_rdata = 32'hBAD0_BAD0;
      tick();
      mem_if.mem_ack   = 1'b0;
      chk("sp_instr", instr, 32'h0010_0113);
      chk("sp_pc",    pc, 32'h0000_0004);
      chk("sp_pcold", pc_old, 32'h0);
      chk("sp_valid", {31'd0, instr_valid}, 32'd1);
      chk("sp_busy",  {31'd0, busy}, 32'd0);
      chk("sb_empty", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage of the multicycle core. It sits directly upstream of instruction decode.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake.
- Latches the returned word into the instruction register (IR), which drives decode's `instr` input.
- Keeps the PC of the latched instruction (`pc_old`) for auipc, branch and jal target computation. The control FSM sequences it with `fetch_en` and `pc_write`.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, IR value after reset (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_en  in  1  control FSM requests a fetch; sampled in IDLE only.
- pc_write  in  1  load PC from pc_next; sampled in IDLE only.
- pc_next  in  32  next PC (branch/jump target or result), from the result mux.
- mem_addr  out  32  instruction memory byte address; always equals pc.
- mem_req  out  1  read request; high throughout WAIT.
- mem_rdata  in  32  instruction word; valid in the cycle mem_ack is high.
- mem_ack  in  1  memory completion; single-cycle pulse, may arrive after any number of cycles.
- instr  out  32  IR contents, feeds decode.
- pc  out  32  current PC (address of the next fetch).
- pc_old  out  32  PC of the instruction held in IR.
- instr_valid  out  1  IR holds a freshly fetched instruction.
- busy  out  1  high in WAIT.
- misalign_err  out  1  sticky; set when a misaligned pc_next is written.

Behaviour:
- Reset values (next edge with reset=1, from any state, including mid-WAIT): state=IDLE, pc=RESET_PC, pc_old=RESET_PC, instr=NOP_INSTR, instr_valid=0, misalign_err=0, mem_req=0.
- A pending memory access is abandoned on reset; an ack arriving afterwards in IDLE is ignored.
- Outputs are combinational from registers only: mem_addr=pc, mem_req=busy=(state==WAIT). There is no combinational input-to-output path.
- States: IDLE, WAIT.
- IDLE:
  - pc_write=1: pc <= {pc_next[31:2],2'b00}. If pc_next[1:0]!=0, misalign_err <= 1 (it stays 1 until reset).
  - fetch_en=1: state <= WAIT, instr_valid <= 0.
  - pc_write and fetch_en in the same cycle: the PC update is applied first, so the fetch uses the new pc (mem_addr in WAIT = new value).
  - Neither asserted: hold all state.
- WAIT:
  - mem_req=1 held, mem_addr stable.
  - fetch_en and pc_write are ignored (the PC cannot change under an outstanding request).
  - On mem_ack=1: instr <= mem_rdata, pc_old <= pc, pc <= pc+4 (32-bit wrap: 32'hFFFF_FFFC -> 32'h0000_0000), instr_valid <= 1, state <= IDLE.
- Latency: request visible the cycle after fetch_en; IR valid the cycle after mem_ack. Minimum fetch is 2 cycles (ack in the first WAIT cycle).
- instr_valid stays 1 and IR holds until the next accepted fetch_en. pc_write does not clear instr_valid.
- mem_ack in IDLE is ignored (spurious).
- Back-to-back: fetch_en may be asserted in the IDLE cycle immediately after completion.

Decomposition:
- params.vh: NOP_INSTR default, RESET_PC default.
- types.svh: fetch_state_t enum {FETCH_IDLE, FETCH_WAIT}.
- Single module; no sub-module warranted. The PC register and IR stay inline because their update conditions are coupled through the FSM.

Test Plan:
- Reset then idle 5 cycles -> pc=0, instr=32'h0000_0013, instr_valid=0, mem_req=0, misalign_err=0.
- fetch_en at pc=0; ack 3 cycles later with rdata=32'h0050_0093 -> mem_req high exactly 3 cycles at addr 0; next cycle instr=32'h0050_0093, pc=4, pc_old=0, instr_valid=1.
- fetch_en+pc_write same IDLE cycle, pc_next=32'h0000_0100 -> mem_addr=0x100 during WAIT; after ack pc=0x104, pc_old=0x100.
- pc_write with pc_next=32'h0000_0102 -> pc=0x100, misalign_err=1 and still 1 after a further fetch; pc_write/fetch_en pulses during WAIT change nothing.
- pc_write pc_next=32'hFFFF_FFFC, fetch, ack -> pc=0, pc_old=32'hFFFF_FFFC.
- reset during WAIT, ack arrives in the following cycle -> state IDLE, instr=NOP, pc=RESET_PC, ack ignored; spurious ack in IDLE leaves IR unchanged.
